// File: rtl/np_pkg.sv
// Shared definitions for the NeoPixel strip controller: register map, command bits,
// sequencer state encoding and small helpers.
package np_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h40;
    localparam logic [7:0] REG_COUNT  = 8'h44;
    localparam logic [7:0] REG_STATUS = 8'h48;

    localparam int CTRL_START   = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_IRQ_ACK = 2;
    localparam int CTRL_ABORT   = 3;

    localparam int CMD_SET  = 24;
    localparam int CMD_SEND = 25;
    localparam int CMD_CLR  = 26;

    localparam int WAIT_CYC_DEFAULT = 8400;
    localparam int IDX_W            = 5;
    localparam int MAX_NPIX         = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FIRE = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } np_state_e;

    function automatic logic [31:0] np_set_cmd(input logic [23:0] pix);
        logic [31:0] w;
        w          = {8'h00, pix};
        w[CMD_SET] = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] np_send_cmd();
        logic [31:0] w;
        w           = '0;
        w[CMD_SEND] = 1'b1;
        return w;
    endfunction

    // Effective pixel count: requested COUNT limited to the buffer depth.
    function automatic logic [IDX_W-1:0] np_clamp(input logic [IDX_W-1:0] cnt, input int npix);
        if (int'(cnt) > npix) return IDX_W'(npix);
        return cnt;
    endfunction

endpackage

// File: rtl/np_strip_ctrl_if.sv
// Register bus between the host and the strip controller.
interface np_strip_ctrl_if;
  logic        bus_write_en;
  logic        bus_read_en;
  logic        ctrl_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;

  modport master (
    output bus_write_en, bus_read_en, ctrl_en, bus_addr, bus_write_data,
    input  bus_read_data
  );

  modport slave (
    input  bus_write_en, bus_read_en, ctrl_en, bus_addr, bus_write_data,
    output bus_read_data
  );
endinterface

// File: rtl/np_pixel_ram.sv
// NPIX x 24-bit GRB pixel store: one write port, combinational bus and sequencer reads.
module np_pixel_ram
  import np_pkg::*;
#(
  parameter int NPIX = 8
) (
  input  logic             pclk,
  input  logic             nreset,
  input  logic             we_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [23:0]      wdata_i,
  input  logic [IDX_W-1:0] bus_raddr_i,
  output logic [23:0]      bus_rdata_o,
  input  logic [IDX_W-1:0] seq_raddr_i,
  output logic [23:0]      seq_rdata_o
);

  logic [23:0] word_w [MAX_NPIX];

  // Slots beyond NPIX are tied to zero so out-of-range reads return 0.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_NPIX; gi++) begin : g_word
      if (gi < NPIX) begin : g_live
        localparam logic [IDX_W-1:0] ADDR = IDX_W'(gi);
        logic [23:0] word_q;

        always_ff @(posedge pclk or negedge nreset) begin
          if (!nreset) begin
            word_q <= '0;
          end else if (clr_i) begin
            word_q <= '0;
          end else if (we_i && (waddr_i == ADDR)) begin
            word_q <= wdata_i;
          end
        end

        assign word_w[gi] = word_q;
      end else begin : g_tie
        assign word_w[gi] = '0;
      end
    end
  endgenerate

  assign bus_rdata_o = bus_raddr_i[IDX_W-1] ? '0 : word_w[bus_raddr_i[IDX_W-2:0]];
  assign seq_rdata_o = seq_raddr_i[IDX_W-1] ? '0 : word_w[seq_raddr_i[IDX_W-2:0]];

endmodule

// File: rtl/np_strip_ctrl.sv
// NeoPixel strip sequencer: holds pixel colours and streams SET/SEND command pairs
// to the pixel driver, spacing pixels by the driver's transmit + latch time.
module np_strip_ctrl
  import np_pkg::*;
#(
  parameter int NPIX     = 8,
  parameter int WAIT_CYC = WAIT_CYC_DEFAULT
) (
  input  logic                  pclk,
  input  logic                  nreset,
  np_strip_ctrl_if.slave        bus,
  output logic                  np_bus_write_en,
  output logic                  np_en,
  output logic [7:0]            np_bus_addr,
  output logic [31:0]           np_bus_write_data,
  output logic                  busy,
  output logic                  irq_done
);

  localparam int             WCW       = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYC - 1);
  localparam logic [7:0]     PIX_END   = 8'(4 * NPIX);

  np_state_e        state_q;
  logic             busy_q;
  logic             irq_q;
  logic             abort_q;
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] cnt_eff_q;
  logic [IDX_W-1:0] count_q;
  logic [WCW-1:0]   wait_q;
  logic             np_we_q;
  logic             np_en_q;
  logic [31:0]      np_data_q;

  logic             wr_sel;
  logic             rd_sel;
  logic             pix_hit;
  logic             ctrl_wr;
  logic             start_cmd;
  logic             clear_cmd;
  logic             ack_cmd;
  logic             abort_cmd;
  logic             pix_we;
  logic             pix_clr;
  logic             count_we;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] seq_raddr;
  logic [23:0]      bus_pix;
  logic [23:0]      seq_pix;
  logic [31:0]      rdata;
  logic             unused_wdata_hi;

  assign wr_sel    = bus.ctrl_en & bus.bus_write_en;
  assign rd_sel    = bus.ctrl_en & bus.bus_read_en;
  assign pix_hit   = (bus.bus_addr < PIX_END) && (bus.bus_addr[1:0] == 2'b00);
  assign ctrl_wr   = wr_sel && (bus.bus_addr == REG_CTRL);
  assign start_cmd = ctrl_wr & bus.bus_write_data[CTRL_START];
  assign clear_cmd = ctrl_wr & bus.bus_write_data[CTRL_CLEAR];
  assign ack_cmd   = ctrl_wr & bus.bus_write_data[CTRL_IRQ_ACK];
  assign abort_cmd = ctrl_wr & bus.bus_write_data[CTRL_ABORT];

  // Pixel, CLEAR and COUNT updates are only honoured between sequences.
  assign pix_we   = wr_sel & pix_hit & (state_q == ST_IDLE);
  assign pix_clr  = clear_cmd & (state_q == ST_IDLE);
  assign count_we = wr_sel && (bus.bus_addr == REG_COUNT) && (state_q == ST_IDLE);

  assign unused_wdata_hi = ^bus.bus_write_data[31:24];

  // The sequencer looks one pixel ahead so the LOAD data can be registered on entry.
  assign idx_next  = index_q + IDX_W'(1);
  assign seq_raddr = (state_q == ST_WAIT) ? idx_next : '0;

  np_pixel_ram #(
    .NPIX (NPIX)
  ) u_pixel_ram (
    .pclk        (pclk),
    .nreset      (nreset),
    .we_i        (pix_we),
    .clr_i       (pix_clr),
    .waddr_i     (bus.bus_addr[6:2]),
    .wdata_i     (bus.bus_write_data[23:0]),
    .bus_raddr_i (bus.bus_addr[6:2]),
    .bus_rdata_o (bus_pix),
    .seq_raddr_i (seq_raddr),
    .seq_rdata_o (seq_pix)
  );

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      count_q <= IDX_W'(NPIX);
    end else if (count_we) begin
      count_q <= bus.bus_write_data[IDX_W-1:0];
    end
  end

  always_ff @(posedge pclk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
      abort_q   <= 1'b0;
      index_q   <= '0;
      cnt_eff_q <= '0;
      wait_q    <= '0;
      np_we_q   <= 1'b0;
      np_en_q   <= 1'b0;
      np_data_q <= '0;
    end else begin
      np_we_q   <= 1'b0;
      np_en_q   <= 1'b0;
      np_data_q <= '0;
      if (ack_cmd) irq_q <= 1'b0;
      if (abort_cmd && (state_q != ST_IDLE)) abort_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start_cmd) begin
            busy_q    <= 1'b1;
            index_q   <= '0;
            abort_q   <= 1'b0;
            cnt_eff_q <= np_clamp(count_q, NPIX);
            if (count_q == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q   <= ST_LOAD;
              np_we_q   <= 1'b1;
              np_en_q   <= 1'b1;
              np_data_q <= np_set_cmd(seq_pix);
            end
          end
        end
        ST_LOAD: begin
          state_q   <= ST_FIRE;
          np_we_q   <= 1'b1;
          np_en_q   <= 1'b1;
          np_data_q <= np_send_cmd();
        end
        ST_FIRE: begin
          wait_q  <= WAIT_LOAD;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - WCW'(1);
          end else begin
            index_q <= idx_next;
            // A pending abort only takes effect here, after the current pixel is latched.
            if ((idx_next < cnt_eff_q) && !abort_q) begin
              state_q   <= ST_LOAD;
              np_we_q   <= 1'b1;
              np_en_q   <= 1'b1;
              np_data_q <= np_set_cmd(seq_pix);
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          irq_q   <= 1'b1;
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_sel) begin
      if (pix_hit) begin
        rdata = {8'h00, bus_pix};
      end else if (bus.bus_addr == REG_COUNT) begin
        rdata = {{(32-IDX_W){1'b0}}, count_q};
      end else if (bus.bus_addr == REG_STATUS) begin
        rdata = {23'b0, index_q, 2'b00, irq_q, busy_q};
      end
    end
  end

  assign bus.bus_read_data  = rdata;
  assign np_bus_write_en    = np_we_q;
  assign np_en              = np_en_q;
  assign np_bus_addr        = 8'h00;
  assign np_bus_write_data  = np_data_q;
  assign busy               = busy_q;
  assign irq_done           = irq_q;

endmodule

// File: tb/tb_np_strip_ctrl.sv
// Randomised scoreboard bench for np_strip_ctrl: expected driver commands are queued
// from a behavioural strip model and checked by an independent monitor.
module tb_np_strip_ctrl;
  import np_pkg::*;

  localparam int NPIX = 8;
  localparam int W    = 20;
  localparam int SP   = W + 2;

  typedef struct {
    int          stamp;
    logic [31:0] data;
  } np_exp_t;

  logic        pclk   = 1'b0;
  logic        nreset = 1'b0;
  logic        np_we;
  logic        np_en_o;
  logic [7:0]  np_addr;
  logic [31:0] np_data;
  logic        busy;
  logic        irq;

  int          edges   = 0;
  int          vectors = 0;
  int          errors  = 0;
  np_exp_t     exp_q[$];
  logic [23:0] model_pix [NPIX];
  logic [4:0]  model_count;

  always #5 pclk = ~pclk;
  always @(posedge pclk) edges <= edges + 1;

  np_strip_ctrl_if bus_if ();

  np_strip_ctrl #(
    .NPIX     (NPIX),
    .WAIT_CYC (W)
  ) dut (
    .pclk              (pclk),
    .nreset            (nreset),
    .bus               (bus_if),
    .np_bus_write_en   (np_we),
    .np_en             (np_en_o),
    .np_bus_addr       (np_addr),
    .np_bus_write_data (np_data),
    .busy              (busy),
    .irq_done          (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every driver command must match the head of the expectation queue.
  always @(negedge pclk) begin
    np_exp_t e;
    if (nreset && np_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL np_unexpected: got %h at edge %0d expected no write", np_data, edges);
      end else begin
        e = exp_q.pop_front();
        check("np_data", np_data, e.data);
        check("np_edge", 32'(edges), 32'(e.stamp));
        check("np_en", {31'b0, np_en_o}, 32'd1);
        check("np_addr", {24'b0, np_addr}, 32'd0);
        $display("np cmd  data %h edge %0d", np_data, edges);
      end
    end
  end

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, output int e);
    bus_if.ctrl_en        = 1'b1;
    bus_if.bus_write_en   = 1'b1;
    bus_if.bus_addr       = a;
    bus_if.bus_write_data = d;
    @(posedge pclk);
    #1;
    e = edges;
    bus_if.bus_write_en = 1'b0;
    bus_if.ctrl_en      = 1'b0;
    $display("bus wr  addr %h data %h edge %0d", a, d, e);
  endtask

  task automatic bus_rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    bus_if.ctrl_en     = 1'b1;
    bus_if.bus_read_en = 1'b1;
    bus_if.bus_addr    = a;
    #2;
    check(name, bus_if.bus_read_data, exp);
    $display("bus rd  addr %h data %h", a, bus_if.bus_read_data);
    bus_if.ctrl_en     = 1'b0;
    bus_if.bus_read_en = 1'b0;
    @(posedge pclk);
    #1;
  endtask

  task automatic go_to_edge(input int t);
    while (edges < t) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic wr_pix(input int i, input logic [23:0] v);
    int e;
    bus_wr(8'(4 * i), {8'h00, v}, e);
    model_pix[i] = v;
  endtask

  task automatic wr_count(input logic [4:0] c);
    int e;
    bus_wr(REG_COUNT, {27'b0, c}, e);
    model_count = c;
  endtask

  // Strip model: n pixels shown, each a SET then SEND, pixels SP cycles apart.
  task automatic expect_seq(input int s, input int abort_px, output int d, output int n);
    np_exp_t x;
    n = (int'(model_count) > NPIX) ? NPIX : int'(model_count);
    if (abort_px >= 0 && abort_px + 1 < n) n = abort_px + 1;
    for (int i = 0; i < n; i++) begin
      x.stamp = s + i * SP;
      x.data  = {8'h01, model_pix[i]};
      exp_q.push_back(x);
      x.stamp = s + i * SP + 1;
      x.data  = 32'h0200_0000;
      exp_q.push_back(x);
    end
    d = (n == 0) ? s + 1 : s + (n - 1) * SP + W + 3;
  endtask

  task automatic wait_done(input string name, input int d);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(negedge pclk);
      k++;
    end
    if (k >= 2000) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: busy still %0d expected 0 by edge %0d", name, busy, d);
    end else begin
      check({name, "_done_edge"}, 32'(edges), 32'(d));
      check({name, "_irq"}, {31'b0, irq}, 32'd1);
    end
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, n, e, cnt, ri;

    bus_if.bus_write_en   = 1'b0;
    bus_if.bus_read_en    = 1'b0;
    bus_if.ctrl_en        = 1'b0;
    bus_if.bus_addr       = 8'h00;
    bus_if.bus_write_data = 32'h0;
    for (int i = 0; i < NPIX; i++) model_pix[i] = 24'h0;
    model_count = 5'(NPIX);

    repeat (3) @(posedge pclk);
    #1;
    nreset = 1'b1;
    @(posedge pclk);
    #1;

    // Reset state
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_np_we", {31'b0, np_we}, 32'd0);
    check("rst_np_data", np_data, 32'd0);
    bus_rd_chk("rst_count", REG_COUNT, 32'(NPIX));
    bus_rd_chk("rst_status", REG_STATUS, 32'h0);
    bus_rd_chk("rst_pix5", 8'h14, 32'h0);
    bus_rd_chk("unmapped", 8'h4C, 32'h0);

    // Three-pixel reference sequence
    wr_pix(0, 24'hFF0000);
    wr_pix(1, 24'h00FF00);
    wr_pix(2, 24'h0000FF);
    wr_count(5'd3);
    bus_rd_chk("count3", REG_COUNT, 32'd3);
    bus_rd_chk("pix1", 8'h04, 32'h0000FF00);
    bus_wr(REG_CTRL, 32'h1, s);
    expect_seq(s, -1, d, n);
    check("t3_busy", {31'b0, busy}, 32'd1);
    wait_done("t3", d);
    bus_rd_chk("t3_status", REG_STATUS, 32'h32);

    // IRQ acknowledge
    bus_wr(REG_CTRL, 32'h4, e);
    check("ack_irq", {31'b0, irq}, 32'd0);
    bus_rd_chk("ack_status", REG_STATUS, 32'h30);

    // COUNT=0: straight to DONE
    wr_count(5'd0);
    bus_wr(REG_CTRL, 32'h1, s);
    expect_seq(s, -1, d, n);
    check("c0_busy", {31'b0, busy}, 32'd1);
    wait_done("c0", d);
    bus_rd_chk("c0_status", REG_STATUS, 32'h2);

    // Abort during the wait of pixel 1 (START+IRQ_ACK together)
    wr_pix(3, 24'h123456);
    wr_pix(4, 24'h654321);
    wr_count(5'd5);
    bus_wr(REG_CTRL, 32'h5, s);
    check("ab_irq_cleared", {31'b0, irq}, 32'd0);
    expect_seq(s, 1, d, n);
    go_to_edge(s + SP + 9);
    bus_wr(REG_CTRL, 32'h8, e);
    wait_done("abort", d);
    bus_rd_chk("ab_status", REG_STATUS, 32'h22);

    // Writes and START while busy are ignored
    wr_count(5'd3);
    bus_wr(REG_CTRL, 32'h5, s);
    expect_seq(s, -1, d, n);
    go_to_edge(s + 4);
    bus_wr(8'h00, 32'h00ABCDEF, e);
    bus_wr(REG_CTRL, 32'h1, e);
    bus_wr(REG_COUNT, 32'h1, e);
    bus_wr(REG_CTRL, 32'h2, e);
    bus_rd_chk("bz_status0", REG_STATUS, 32'h001);
    go_to_edge(s + SP + 8);
    bus_rd_chk("bz_status1", REG_STATUS, 32'h011);
    bus_rd_chk("bz_pix0_busy", 8'h00, {8'h00, model_pix[0]});
    wait_done("busy", d);
    bus_rd_chk("bz_count", REG_COUNT, 32'd3);
    bus_rd_chk("bz_pix0", 8'h00, {8'h00, model_pix[0]});

    // Randomised sequences; the first uses COUNT=20 to exercise clamping
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < NPIX; i++) wr_pix(i, 24'($urandom()));
      cnt = (it == 0) ? 20 : int'($urandom_range(0, 20));
      wr_count(5'(cnt));
      bus_rd_chk("rnd_count", REG_COUNT, 32'(cnt));
      ri = int'($urandom_range(0, NPIX - 1));
      bus_rd_chk("rnd_pix", 8'(4 * ri), {8'h00, model_pix[ri]});
      bus_wr(REG_CTRL, 32'h5, s);
      check("rnd_irq_cleared", {31'b0, irq}, 32'd0);
      expect_seq(s, -1, d, n);
      wait_done("rnd", d);
      bus_rd_chk("rnd_status", REG_STATUS, 32'((n << 4) | 2));
    end

    // CLEAR while idle
    bus_wr(REG_CTRL, 32'h6, e);
    for (int i = 0; i < NPIX; i++) model_pix[i] = 24'h0;
    bus_rd_chk("clr_pix0", 8'h00, 32'h0);
    bus_rd_chk("clr_pix7", 8'h1C, 32'h0);

    // Reset in the wait of pixel 2, then START on the first edge after release
    for (int i = 0; i < 4; i++) wr_pix(i, 24'($urandom()) | 24'h1);
    wr_count(5'd4);
    bus_wr(REG_CTRL, 32'h1, s);
    expect_seq(s, -1, d, n);
    go_to_edge(s + 2 * SP + 6);
    nreset = 1'b0;
    #1;
    check("mr_np_we", {31'b0, np_we}, 32'd0);
    check("mr_np_en", {31'b0, np_en_o}, 32'd0);
    check("mr_np_data", np_data, 32'd0);
    check("mr_busy", {31'b0, busy}, 32'd0);
    check("mr_irq", {31'b0, irq}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) model_pix[i] = 24'h0;
    model_count = 5'(NPIX);
    @(posedge pclk);
    #1;
    bus_rd_chk("mr_count", REG_COUNT, 32'(NPIX));
    bus_rd_chk("mr_pix1", 8'h04, 32'h0);
    nreset = 1'b1;
    bus_wr(REG_CTRL, 32'h1, s);
    expect_seq(s, -1, d, n);
    check("mr_start_busy", {31'b0, busy}, 32'd1);
    wait_done("mr", d);
    bus_rd_chk("mr_status", REG_STATUS, 32'h82);

    repeat (5) @(posedge pclk);
    #1;
    check("np_missing", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
